// File: rtl/ft_mem_pkg.sv
// Shared types and helpers for the checkpoint memory.
// The parity helper is only called when FT_MEM_PARITY_EN is defined.
package ft_mem_pkg;

    typedef enum logic [1:0] {
        RsIdle,
        RsRegs,
        RsPc
    } rs_state_e;

    // The word index just past the register file addresses the committed PC.
    function automatic int unsigned pc_index(input int unsigned num_regs);
        return num_regs;
    endfunction

    // Even-parity bit: set when the word has an odd number of ones.
    // Narrower words are zero-extended by the caller, which leaves parity unchanged.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ft_mem_restore_fsm.sv
// Restore sequencer: one register beat per cycle, then a single PC/done cycle.
module ft_mem_restore_fsm
    import ft_mem_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    localparam int unsigned IDX_W = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             beat_we,
    output logic [IDX_W-1:0] beat_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    rs_state_e state;

    // State, beat counter and registered stream controls; start is only honoured when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RsIdle;
            busy     <= 1'b0;
            done     <= 1'b0;
            beat_we  <= 1'b0;
            beat_idx <= '0;
        end else begin
            case (state)
                RsIdle: begin
                    if (start) begin
                        state    <= RsRegs;
                        busy     <= 1'b1;
                        beat_we  <= 1'b1;
                        beat_idx <= '0;
                    end
                end
                RsRegs: begin
                    if (beat_idx == LAST_IDX) begin
                        state    <= RsPc;
                        beat_we  <= 1'b0;
                        done     <= 1'b1;
                        beat_idx <= '0;
                    end else begin
                        beat_idx <= beat_idx + IDX_W'(1);
                    end
                end
                RsPc: begin
                    state <= RsIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= RsIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    beat_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ft_checkpoint_mem.sv
// Checkpoint memory: working/committed register + PC arrays, a one-cycle-latency
// read port onto the committed copy, and a restore stream back to the register file.
// Optional FT_MEM_PARITY_EN adds an even-parity bit per committed word.
module ft_checkpoint_mem
    import ft_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_rf_i,
    input  logic [$clog2(NUM_REGS)-1:0] addr_rf_i,
    input  logic [DATA_WIDTH-1:0]       data_rf_i,
    input  logic [DATA_WIDTH-1:0]       pc_i,
    input  logic                        commit_i,
    input  logic                        restore_i,
    input  logic                        req_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic                        err_o,
    output logic                        rs_we_o,
    output logic [$clog2(NUM_REGS)-1:0] rs_addr_o,
    output logic [DATA_WIDTH-1:0]       rs_data_o,
    output logic                        rs_busy_o,
    output logic                        rs_done_o,
    output logic [DATA_WIDTH-1:0]       rs_pc_o
);

    localparam int unsigned REG_AW = $clog2(NUM_REGS);
    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(pc_index(NUM_REGS));

    logic [DATA_WIDTH-1:0] work_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] work_next [NUM_REGS];
    logic [DATA_WIDTH-1:0] work_pc, work_pc_next;
    logic [DATA_WIDTH-1:0] comm_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] comm_pc;
`ifdef FT_MEM_PARITY_EN
    logic                  comm_par [NUM_REGS];
    logic                  comm_pc_par;
`endif

    logic                  restore_go, commit_go;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_err;
    logic                  unused_addr_lsbs;

    assign restore_go       = restore_i & ~rs_busy_o;
    assign commit_go        = commit_i & ~restore_i & ~rs_busy_o;
    assign gnt_o            = req_i & ~rs_busy_o;
    assign rd_idx           = addr_i[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^addr_i[1:0];

    ft_mem_restore_fsm #(
        .NUM_REGS(NUM_REGS)
    ) u_restore_fsm (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (restore_i),
        .busy     (rs_busy_o),
        .done     (rs_done_o),
        .beat_we  (rs_we_o),
        .beat_idx (rs_addr_o)
    );

    assign rs_data_o = rs_we_o ? comm_regs[rs_addr_o] : '0;
    assign rs_pc_o   = rs_done_o ? comm_pc : '0;

    // Next working state; a commit copies this so a same-cycle write is forwarded.
    always_comb begin
        work_next    = work_regs;
        work_pc_next = work_pc;
        if (restore_go) begin
            work_next    = comm_regs;
            work_pc_next = comm_pc;
        end else if (!rs_busy_o) begin
            if (we_rf_i) begin
                work_next[addr_rf_i] = data_rf_i;
            end
            work_pc_next = pc_i;
        end
    end

    // Working array: captures writes and the live PC, reloaded from committed on restore.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                work_regs[i] <= '0;
            end
            work_pc <= '0;
        end else begin
            work_regs <= work_next;
            work_pc   <= work_pc_next;
        end
    end

    // Committed array: whole-array snapshot on an accepted commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                comm_regs[i] <= '0;
`ifdef FT_MEM_PARITY_EN
                comm_par[i]  <= 1'b0;
`endif
            end
            comm_pc <= '0;
`ifdef FT_MEM_PARITY_EN
            comm_pc_par <= 1'b0;
`endif
        end else if (commit_go) begin
            comm_regs <= work_next;
            comm_pc   <= work_pc_next;
`ifdef FT_MEM_PARITY_EN
            for (int i = 0; i < NUM_REGS; i++) begin
                comm_par[i] <= even_parity(64'(work_next[i]));
            end
            comm_pc_par <= even_parity(64'(work_pc_next));
`endif
        end
    end

    // Read decode against the committed copy as it stands before this edge.
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        if (rd_idx < PC_IDX) begin
            rd_word = comm_regs[rd_idx[REG_AW-1:0]];
`ifdef FT_MEM_PARITY_EN
            rd_err  = even_parity(64'(rd_word)) != comm_par[rd_idx[REG_AW-1:0]];
`endif
        end else if (rd_idx == PC_IDX) begin
            rd_word = comm_pc;
`ifdef FT_MEM_PARITY_EN
            rd_err  = even_parity(64'(rd_word)) != comm_pc_par;
`endif
        end else begin
            rd_err = 1'b1;
        end
    end

    // Response register: one beat per grant, zeroed when no grant was issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= gnt_o;
            rdata_o  <= gnt_o ? rd_word : '0;
            err_o    <= gnt_o & rd_err;
        end
    end

endmodule

// File: tb/tb_ft_checkpoint_mem.sv
// Self-checking bench for ft_checkpoint_mem with a cycle-level reference model.
module tb_ft_checkpoint_mem;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          we_rf_i;
    logic [4:0]    addr_rf_i;
    logic [DW-1:0] data_rf_i;
    logic [DW-1:0] pc_i;
    logic          commit_i;
    logic          restore_i;
    logic          req_i;
    logic          gnt_o;
    logic          rvalid_o;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic          rs_we_o;
    logic [4:0]    rs_addr_o;
    logic [DW-1:0] rs_data_o;
    logic          rs_busy_o;
    logic          rs_done_o;
    logic [DW-1:0] rs_pc_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] m_work [NR];
    logic [DW-1:0] m_comm [NR];
    logic [DW-1:0] m_work_pc, m_comm_pc;
    int            m_phase;
    logic          e_gnt, o_gnt;
    logic          e_rvalid, e_err;
    logic [DW-1:0] e_rdata;

    always #5 clk = ~clk;

    ft_checkpoint_mem #(
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .we_rf_i  (we_rf_i),
        .addr_rf_i(addr_rf_i),
        .data_rf_i(data_rf_i),
        .pc_i     (pc_i),
        .commit_i (commit_i),
        .restore_i(restore_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .addr_i   (addr_i),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .rs_we_o  (rs_we_o),
        .rs_addr_o(rs_addr_o),
        .rs_data_o(rs_data_o),
        .rs_busy_o(rs_busy_o),
        .rs_done_o(rs_done_o),
        .rs_pc_o  (rs_pc_o)
    );

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_work[i] = '0;
            m_comm[i] = '0;
        end
        m_work_pc = '0;
        m_comm_pc = '0;
        m_phase   = -1;
        e_rvalid  = 1'b0;
        e_rdata   = '0;
        e_err     = 1'b0;
    endtask

    // Drive one cycle of inputs, advance one clock and update the model.
    // Called at posedge+1; returns at the following posedge+1.
    task automatic tick(input logic we, input logic [4:0] wa, input logic [DW-1:0] wd,
                        input logic [DW-1:0] pc, input logic cm, input logic rs,
                        input logic rq, input logic [AW-1:0] ra);
        int unsigned idx;
        we_rf_i   = we;
        addr_rf_i = wa;
        data_rf_i = wd;
        pc_i      = pc;
        commit_i  = cm;
        restore_i = rs;
        req_i     = rq;
        addr_i    = ra;
        #1;
        o_gnt = gnt_o;
        e_gnt = rq && (m_phase < 0);
        @(posedge clk);
        e_rvalid = e_gnt;
        e_rdata  = '0;
        e_err    = 1'b0;
        if (e_gnt) begin
            idx = ra >> 2;
            if (idx < NR) e_rdata = m_comm[idx];
            else if (idx == NR) e_rdata = m_comm_pc;
            else e_err = 1'b1;
        end
        if (m_phase < 0) begin
            if (rs) begin
                m_work    = m_comm;
                m_work_pc = m_comm_pc;
                m_phase   = 0;
            end else begin
                if (we) m_work[wa] = wd;
                m_work_pc = pc;
                if (cm) begin
                    m_comm    = m_work;
                    m_comm_pc = m_work_pc;
                end
            end
        end else if (m_phase == NR) begin
            m_phase = -1;
        end else begin
            m_phase++;
        end
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({gnt_o, rvalid_o, err_o, rs_we_o, rs_busy_o, rs_done_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {gnt_o, rvalid_o, err_o, rs_we_o, rs_busy_o, rs_done_o});
        end
        vectors++;
        if ({rdata_o, rs_addr_o, rs_data_o, rs_pc_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rdata %h rs_addr %h rs_data %h rs_pc %h want 0",
                     rdata_o, rs_addr_o, rs_data_o, rs_pc_o);
        end
        rst_i = 1'b0;
        tick(0, 0, 0, 0, 0, 0, 1, 32'h0);
        vectors++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read_r0: rvalid %b rdata %h err %b want 1 0 0",
                     rvalid_o, rdata_o, err_o);
        end
    endtask

    task automatic test_write_commit_read();
        tick(1, 5, 32'hDEADBEEF, 32'h100, 0, 0, 0, 0);
        tick(0, 0, 0, 32'h104, 1, 0, 0, 0);
        tick(0, 0, 0, 32'h108, 0, 0, 1, 32'h14);
        vectors++;
        if (o_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_gnt: got %b want 1", o_gnt);
        end
        vectors++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEADBEEF || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_read_r5: rvalid %b rdata %h err %b want 1 deadbeef 0",
                     rvalid_o, rdata_o, err_o);
        end
        tick(0, 0, 0, 32'h10C, 0, 0, 0, 0);
        vectors++;
        if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle_zero: rvalid %b rdata %h err %b want 0 0 0",
                     rvalid_o, rdata_o, err_o);
        end
    endtask

    task automatic test_commit_forward();
        tick(1, 3, 32'h11, 32'h80, 1, 0, 0, 0);
        tick(0, 0, 0, 32'h84, 0, 0, 1, 32'h0C);
        vectors++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h11) begin
            miscompares++;
            $display("FAIL fwd_r3: rvalid %b rdata %h want 1 00000011", rvalid_o, rdata_o);
        end
        tick(0, 0, 0, 32'h88, 0, 0, 1, 32'h80);
        vectors++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h80 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_pc: rvalid %b rdata %h err %b want 1 00000080 0",
                     rvalid_o, rdata_o, err_o);
        end
    endtask

    task automatic test_out_of_range_back_to_back();
        tick(0, 0, 0, 0, 0, 0, 1, 32'h84);
        vectors++;
        if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL oob_read: rvalid %b err %b rdata %h want 1 1 0",
                     rvalid_o, err_o, rdata_o);
        end
        tick(0, 0, 0, 0, 0, 0, 1, 32'h00);
        vectors++;
        if (rvalid_o !== 1'b1 || err_o !== 1'b0 || rdata_o !== e_rdata) begin
            miscompares++;
            $display("FAIL b2b_first: rvalid %b err %b rdata %h want 1 0 %h",
                     rvalid_o, err_o, rdata_o, e_rdata);
        end
        tick(0, 0, 0, 0, 0, 0, 1, 32'h84);
        vectors++;
        if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_second: rvalid %b err %b rdata %h want 1 1 0",
                     rvalid_o, err_o, rdata_o);
        end
        tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_restore();
        for (int i = 0; i < NR; i++) tick(1, 5'(i), DW'(i), 32'h200, 0, 0, 0, 0);
        tick(0, 0, 0, 32'h240, 1, 0, 0, 0);
        // Uncommitted write, then restore with a competing commit that must be dropped
        tick(1, 1, 32'h55, 32'h244, 0, 0, 0, 0);
        tick(0, 0, 0, 32'h248, 1, 1, 0, 0);
        for (int b = 0; b <= NR; b++) begin
            if (b < NR) begin
                vectors++;
                if (rs_we_o !== 1'b1 || rs_addr_o !== 5'(b) || rs_data_o !== DW'(b)
                    || rs_busy_o !== 1'b1 || rs_done_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL restore_beat%0d: we %b addr %0d data %h busy %b done %b",
                             b, rs_we_o, rs_addr_o, rs_data_o, rs_busy_o, rs_done_o);
                end
            end else begin
                vectors++;
                if (rs_done_o !== 1'b1 || rs_pc_o !== 32'h240 || rs_busy_o !== 1'b1
                    || rs_we_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL restore_done: done %b pc %h busy %b we %b want 1 240 1 0",
                             rs_done_o, rs_pc_o, rs_busy_o, rs_we_o);
                end
            end
            tick(1, 9, 32'hBAD, 32'h999, 1, 1, 1, 32'h0);
            vectors++;
            if (o_gnt !== 1'b0 || rvalid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL restore_gnt%0d: gnt %b rvalid %b want 0 0", b, o_gnt, rvalid_o);
            end
        end
        vectors++;
        if (rs_busy_o !== 1'b0 || rs_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL restore_end: busy %b done %b want 0 0", rs_busy_o, rs_done_o);
        end
        tick(0, 0, 0, 0, 0, 0, 1, 32'h24);
        vectors++;
        if (rdata_o !== 32'h9 || rvalid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL restore_ignored_commit: rdata %h rvalid %b want 9 1",
                     rdata_o, rvalid_o);
        end
    endtask

    task automatic test_reset_mid_restore();
        tick(0, 0, 0, 0, 0, 1, 0, 0);
        for (int b = 0; b < 10; b++) tick(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (rs_addr_o !== 5'd10 || rs_we_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_beat10: addr %0d we %b want 10 1", rs_addr_o, rs_we_o);
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        vectors++;
        if ({gnt_o, rvalid_o, err_o, rs_we_o, rs_busy_o, rs_done_o} !== 6'b0
            || {rdata_o, rs_addr_o, rs_data_o, rs_pc_o} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: flags %b rs_addr %h rs_data %h rs_pc %h want 0",
                     {gnt_o, rvalid_o, err_o, rs_we_o, rs_busy_o, rs_done_o},
                     rs_addr_o, rs_data_o, rs_pc_o);
        end
        rst_i = 1'b0;
        tick(0, 0, 0, 0, 0, 0, 1, 32'h0);
        vectors++;
        if (o_gnt !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_read_r0: gnt %b rvalid %b rdata %h want 1 1 0",
                     o_gnt, rvalid_o, rdata_o);
        end
        tick(0, 0, 0, 0, 0, 0, 1, 32'h14);
        vectors++;
        if (rdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_read_r5: rdata %h want 0", rdata_o);
        end
    endtask

    task automatic test_random();
        logic        we, cm, rs, rq;
        logic [AW-1:0] ra;
        logic        x_we;
        for (int n = 0; n < 600; n++) begin
            we = ($urandom_range(0, 1) == 1);
            cm = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 59) == 0);
            rq = ($urandom_range(0, 1) == 1);
            ra = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 34) << 2);
            tick(we, 5'($urandom), DW'($urandom), DW'($urandom), cm, rs, rq, ra);
            vectors++;
            if (o_gnt !== e_gnt) begin
                miscompares++;
                $display("FAIL rnd_gnt@%0d: got %b want %b", n, o_gnt, e_gnt);
            end
            vectors++;
            if (rvalid_o !== e_rvalid || rdata_o !== e_rdata || err_o !== e_err) begin
                miscompares++;
                $display("FAIL rnd_resp@%0d: got %b %h %b want %b %h %b", n,
                         rvalid_o, rdata_o, err_o, e_rvalid, e_rdata, e_err);
            end
            x_we = (m_phase >= 0) && (m_phase < NR);
            vectors++;
            if (rs_busy_o !== (m_phase >= 0) || rs_we_o !== x_we
                || rs_done_o !== (m_phase == NR)) begin
                miscompares++;
                $display("FAIL rnd_rs_ctl@%0d: busy %b we %b done %b phase %0d", n,
                         rs_busy_o, rs_we_o, rs_done_o, m_phase);
            end
            if (x_we) begin
                vectors++;
                if (rs_addr_o !== 5'(m_phase) || rs_data_o !== m_comm[m_phase]) begin
                    miscompares++;
                    $display("FAIL rnd_rs_beat@%0d: addr %0d data %h want %0d %h", n,
                             rs_addr_o, rs_data_o, m_phase, m_comm[m_phase]);
                end
            end
            if (m_phase == NR) begin
                vectors++;
                if (rs_pc_o !== m_comm_pc) begin
                    miscompares++;
                    $display("FAIL rnd_rs_pc@%0d: got %h want %h", n, rs_pc_o, m_comm_pc);
                end
            end
        end
        // Let any restore in progress drain
        for (int n = 0; n < NR + 2; n++) tick(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

`ifdef FT_MEM_PARITY_EN
    task automatic test_parity();
        tick(1, 7, 32'h0F0F_0F0F, 0, 1, 0, 0, 0);
        dut.comm_regs[7] = dut.comm_regs[7] ^ 32'h1;
        tick(0, 0, 0, 0, 0, 0, 1, 32'h1C);
        vectors++;
        if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0F0F_0F0E) begin
            miscompares++;
            $display("FAIL parity_err: rvalid %b err %b rdata %h want 1 1 0f0f0f0e",
                     rvalid_o, err_o, rdata_o);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        we_rf_i = 0; addr_rf_i = 0; data_rf_i = 0; pc_i = 0;
        commit_i = 0; restore_i = 0; req_i = 0; addr_i = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_write_commit_read();
        test_commit_forward();
        test_out_of_range_back_to_back();
        test_restore();
        test_reset_mid_restore();
        test_random();
`ifdef FT_MEM_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
